// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding-request memory FSM feeding a small prefetch FIFO for the decoder.
// Latency: a returned word reaches instr_o one cycle after instr_rvalid_i; there is no bypass.
// Backpressure: stall_i holds the FIFO head, and requests stop once buffered plus outstanding words fill the FIFO.
module fetch_unit #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  no_op_flag_o,
    input  logic                  stall_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_target_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WORD_WIDTH-1:0] NOP = WORD_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, DISCARD} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] fetch_addr;
    logic [WORD_WIDTH-1:0] rsp_addr;
    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  space_after_push;
    logic [WORD_WIDTH-1:0] target_aligned;
    logic [1:0]            unused_target_lsbs;

    assign target_aligned     = {branch_target_i[WORD_WIDTH-1:2], 2'b00};
    assign unused_target_lsbs = branch_target_i[1:0];

    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && !stall_i && !branch_i;
    assign push       = (state == WAIT_RVALID) && instr_rvalid_i && !branch_i;
    // A push only happens with count below depth, so the only full case is count==DEPTH-1 without a pop.
    assign space_after_push = !((count == CNT_W'(FIFO_DEPTH - 1)) && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_addr <= BOOT_ADDR;
            rsp_addr   <= BOOT_ADDR;
        end else if (branch_i) begin
            fetch_addr <= target_aligned;
            case (state)
                IDLE:     state <= WAIT_GNT;
                // A grant taken in the branch cycle was for the old path; its data must be dropped.
                WAIT_GNT: state <= instr_gnt_i ? DISCARD : WAIT_GNT;
                default:  state <= instr_rvalid_i ? WAIT_GNT : DISCARD;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count < CNT_W'(FIFO_DEPTH)) state <= WAIT_GNT;
                end
                WAIT_GNT: begin
                    if (instr_gnt_i) begin
                        state      <= WAIT_RVALID;
                        rsp_addr   <= fetch_addr;
                        fetch_addr <= fetch_addr + WORD_WIDTH'(4);
                    end
                end
                WAIT_RVALID: begin
                    if (instr_rvalid_i) state <= space_after_push ? WAIT_GNT : IDLE;
                end
                DISCARD: begin
                    if (instr_rvalid_i) state <= WAIT_GNT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_q   <= BOOT_ADDR;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            // pc_o keeps showing the last head once the buffer drains.
            if (!fifo_empty) pc_q <= pc_mem[rd_ptr];
            if (branch_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    instr_mem[wr_ptr] <= instr_rdata_i;
                    pc_mem[wr_ptr]    <= rsp_addr;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    assign instr_req_o  = (state == WAIT_GNT);
    assign instr_addr_o = fetch_addr;
    assign no_op_flag_o = fifo_empty || branch_i;
    assign instr_o      = fifo_empty ? NOP : instr_mem[rd_ptr];
    assign pc_o         = fifo_empty ? pc_q : pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a stream-level model.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req, gnt, rvalid, stall, branch, noop;
    logic [31:0] addr, rdata, instr, pc, target;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory-side bookkeeping used by directed scenarios.
    bit          pend;
    logic [31:0] pend_addr;
    logic [31:0] grant_q[$];

    fetch_unit #(.WORD_WIDTH(32), .BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
        .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
        .instr_o(instr), .pc_o(pc), .no_op_flag_o(noop),
        .stall_i(stall), .branch_i(branch), .branch_target_i(target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        gnt = 0; rvalid = 0; rdata = 0; stall = 0; branch = 0; target = 0;
        pend = 0; pend_addr = 0; grant_q.delete();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // One cycle of a memory that returns data the cycle after a grant.
    task automatic mem_cycle(input bit g, input bit s);
        stall = s; gnt = g; branch = 0;
        rvalid = pend;
        rdata  = pend ? mem_word(pend_addr) : 32'h0;
        #1;
        if (req && g) begin
            grant_q.push_back(addr);
            pend_addr = addr;
        end
        pend = req && g;
        tick();
    endtask

    task automatic test_reset();
        gnt = 0; rvalid = 0; rdata = 0; stall = 0; branch = 0; target = 0;
        #2 rst_n = 0;
        tick();
        n_checks++; if (req !== 1'b0) $display("FAIL reset_req: got %b want 0", req); else n_pass++;
        n_checks++; if (addr !== BOOT) $display("FAIL reset_addr: got %h want %h", addr, BOOT); else n_pass++;
        n_checks++; if (instr !== NOP) $display("FAIL reset_instr: got %h want %h", instr, NOP); else n_pass++;
        n_checks++; if (pc !== BOOT) $display("FAIL reset_pc: got %h want %h", pc, BOOT); else n_pass++;
        n_checks++; if (noop !== 1'b1) $display("FAIL reset_noop: got %b want 1", noop); else n_pass++;
    endtask

    task automatic test_first_fetch();
        do_reset();
        gnt = 1;
        tick();
        n_checks++; if (req !== 1'b1) $display("FAIL first_req: got %b want 1", req); else n_pass++;
        n_checks++; if (addr !== 32'h0) $display("FAIL first_addr: got %h want 0", addr); else n_pass++;
        tick();
        gnt = 0; rvalid = 1; rdata = 32'h0050_0093;
        #1;
        n_checks++; if (noop !== 1'b1) $display("FAIL first_no_bypass: got %b want 1", noop); else n_pass++;
        tick();
        rvalid = 0;
        #1;
        n_checks++; if (instr !== 32'h0050_0093) $display("FAIL first_instr: got %h want 00500093", instr); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL first_pc: got %h want 0", pc); else n_pass++;
        n_checks++; if (noop !== 1'b0) $display("FAIL first_noop: got %b want 0", noop); else n_pass++;
        n_checks++; if (req !== 1'b1 || addr !== 32'h4) $display("FAIL first_next_req: got req=%b addr=%h want 1/4", req, addr); else n_pass++;
    endtask

    task automatic test_stall_fill();
        do_reset();
        repeat (12) mem_cycle(1, 1);
        n_checks++; if (grant_q.size() != 2) $display("FAIL fill_count: got %0d want 2", grant_q.size()); else n_pass++;
        if (grant_q.size() == 2) begin
            n_checks++; if (grant_q[0] !== 32'h0 || grant_q[1] !== 32'h4) $display("FAIL fill_addrs: got %h,%h want 0,4", grant_q[0], grant_q[1]); else n_pass++;
        end
        n_checks++; if (req !== 1'b0) $display("FAIL fill_req_low: got %b want 0", req); else n_pass++;
        n_checks++; if (instr !== mem_word(0) || pc !== 32'h0) $display("FAIL fill_head: got %h@%h want %h@0", instr, pc, mem_word(0)); else n_pass++;
        n_checks++; if (noop !== 1'b0) $display("FAIL fill_noop: got %b want 0", noop); else n_pass++;
    endtask

    task automatic test_push_pop();
        logic [31:0] want_pc;
        do_reset();
        repeat (4) mem_cycle(1, 1);
        mem_cycle(1, 0);
        want_pc = 32'h4;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (pc !== want_pc || instr !== mem_word(want_pc) || noop !== 1'b0)
                $display("FAIL pushpop_%0d: got pc=%h instr=%h noop=%b want pc=%h instr=%h noop=0", k, pc, instr, noop, want_pc, mem_word(want_pc));
            else n_pass++;
            if (k < 2) begin
                mem_cycle(1, 1);
                mem_cycle(1, 0);
                want_pc = want_pc + 4;
            end
        end
        mem_cycle(0, 0);
        n_checks++; if (noop !== 1'b1 || instr !== NOP) $display("FAIL pushpop_drain: got noop=%b instr=%h want 1/%h", noop, instr, NOP); else n_pass++;
        n_checks++; if (pc !== 32'hC) $display("FAIL pushpop_pc_hold: got %h want c", pc); else n_pass++;
    endtask

    task automatic test_branch_in_rvalid();
        do_reset();
        mem_cycle(0, 0);
        mem_cycle(1, 0);
        branch = 1; target = 32'h0000_0102; gnt = 0; rvalid = 0;
        #1;
        n_checks++; if (noop !== 1'b1) $display("FAIL brv_noop_branch: got %b want 1", noop); else n_pass++;
        tick();
        branch = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (req !== 1'b0 || noop !== 1'b1) $display("FAIL brv_discard: got req=%b noop=%b want 0/1", req, noop); else n_pass++;
        tick();
        rvalid = 0;
        #1;
        n_checks++; if (req !== 1'b1 || addr !== 32'h100) $display("FAIL brv_target_req: got req=%b addr=%h want 1/100", req, addr); else n_pass++;
        n_checks++; if (noop !== 1'b1) $display("FAIL brv_dropped: got noop=%b want 1", noop); else n_pass++;
        pend = 0;
        mem_cycle(1, 0);
        n_checks++; if (noop !== 1'b1) $display("FAIL brv_wait_word: got noop=%b want 1", noop); else n_pass++;
        mem_cycle(0, 0);
        n_checks++; if (noop !== 1'b0 || pc !== 32'h100 || instr !== mem_word(32'h100))
            $display("FAIL brv_target_word: got noop=%b pc=%h instr=%h want 0/100/%h", noop, pc, instr, mem_word(32'h100));
        else n_pass++;
    endtask

    task automatic test_branch_in_gnt();
        do_reset();
        mem_cycle(0, 0);
        for (int k = 1; k <= 5; k++) begin
            gnt = 0; rvalid = 0; stall = 0;
            branch = (k == 2); target = 32'h80;
            #1;
            n_checks++; if (req !== 1'b1) $display("FAIL bgnt_req_c%0d: got %b want 1", k, req); else n_pass++;
            n_checks++; if (addr !== ((k >= 3) ? 32'h80 : 32'h0)) $display("FAIL bgnt_addr_c%0d: got %h want %h", k, addr, (k >= 3) ? 32'h80 : 32'h0); else n_pass++;
            tick();
        end
        branch = 0;
        mem_cycle(1, 0);
        mem_cycle(0, 0);
        n_checks++; if (pc !== 32'h80 || instr !== mem_word(32'h80) || noop !== 1'b0)
            $display("FAIL bgnt_word: got pc=%h instr=%h noop=%b want 80/%h/0", pc, instr, noop, mem_word(32'h80));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_cycle(0, 0);
        mem_cycle(1, 0);
        rst_n = 0; gnt = 0; rvalid = 0;
        #1;
        n_checks++; if (req !== 1'b0 || addr !== BOOT || instr !== NOP || pc !== BOOT || noop !== 1'b1)
            $display("FAIL rstmid_outputs: got req=%b addr=%h instr=%h pc=%h noop=%b want 0/%h/%h/%h/1", req, addr, instr, pc, noop, BOOT, NOP, BOOT);
        else n_pass++;
        tick();
        rst_n = 1; rvalid = 1; rdata = 32'hBAD0_BAD0;
        tick();
        rvalid = 0; pend = 0;
        #1;
        n_checks++; if (noop !== 1'b1) $display("FAIL rstmid_late_rvalid: got noop=%b want 1", noop); else n_pass++;
        n_checks++; if (req !== 1'b1 || addr !== BOOT) $display("FAIL rstmid_boot_req: got req=%b addr=%h want 1/%h", req, addr, BOOT); else n_pass++;
        tick();
        n_checks++; if (noop !== 1'b1) $display("FAIL rstmid_still_empty: got noop=%b want 1", noop); else n_pass++;
    endtask

    // Model: the decoder sees sequential words from the last redirect; words requested
    // before a redirect (or returned in its cycle) never reach it.
    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] next_fetch, last_pc, m_addr, tgt;
        int          m_delay, epoch, m_epoch;
        bit          m_busy, grant, rv, exp_noop;
        do_reset();
        next_fetch = BOOT; last_pc = BOOT; m_addr = 0;
        epoch = 0; m_epoch = 0; m_busy = 0; m_delay = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall  = ($urandom_range(0, 99) < 30);
            branch = ($urandom_range(0, 99) < 5);
            tgt    = $urandom & 32'h0000_0FFF;
            target = tgt;
            rv     = m_busy && (m_delay == 0);
            rvalid = rv;
            rdata  = rv ? mem_word(m_addr) : $urandom;
            gnt    = ($urandom_range(0, 99) < 60);
            #1;
            exp_noop = (q.size() == 0) || branch;
            n_checks++; if (noop !== exp_noop) $display("FAIL rnd_noop cyc %0d: got %b want %b", cyc, noop, exp_noop); else n_pass++;
            if (q.size() == 0) begin
                n_checks++; if (instr !== NOP || pc !== last_pc) $display("FAIL rnd_empty cyc %0d: got %h@%h want %h@%h", cyc, instr, pc, NOP, last_pc); else n_pass++;
            end else begin
                n_checks++; if (pc !== q[0] || instr !== mem_word(q[0])) $display("FAIL rnd_head cyc %0d: got %h@%h want %h@%h", cyc, instr, pc, mem_word(q[0]), q[0]); else n_pass++;
            end
            if (req) begin
                n_checks++; if (m_busy || q.size() >= DEPTH) $display("FAIL rnd_req_legal cyc %0d: got busy=%b buffered=%0d want busy=0 buffered<%0d", cyc, m_busy, q.size(), DEPTH); else n_pass++;
                n_checks++; if (addr !== next_fetch) $display("FAIL rnd_addr cyc %0d: got %h want %h", cyc, addr, next_fetch); else n_pass++;
            end
            grant = req && gnt;
            if (q.size() != 0) last_pc = q[0];
            if (rv) m_busy = 0;
            else if (m_busy) m_delay--;
            if (!branch && !stall && q.size() != 0) void'(q.pop_front());
            if (rv && !branch && m_epoch == epoch) q.push_back(m_addr);
            if (grant) begin
                m_busy = 1; m_addr = next_fetch; m_epoch = epoch;
                m_delay = $urandom_range(0, 3);
                next_fetch = next_fetch + 4;
            end
            if (branch) begin
                q.delete();
                next_fetch = {tgt[31:2], 2'b00};
                epoch++;
            end
            n_checks++; if (q.size() > DEPTH) $display("FAIL rnd_overflow cyc %0d: got %0d buffered want <=%0d", cyc, q.size(), DEPTH); else n_pass++;
            tick();
        end
        branch = 0; stall = 0; gnt = 0; rvalid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_fill();
        test_push_pop();
        test_branch_in_rvalid();
        test_branch_in_gnt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, giving the instruction and address width.
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, giving the number of prefetch buffer entries (power of two, >=2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset; all state SHALL reset asynchronously.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 instr_req_o  output  1  memory request.
REQ-008 instr_addr_o  output  WORD_WIDTH  word-aligned fetch address.
REQ-009 instr_gnt_i  input  1  request accepted this cycle.
REQ-010 instr_rvalid_i  input  1  read data valid this cycle.
REQ-011 instr_rdata_i  input  WORD_WIDTH  fetched instruction.
REQ-012 instr_o  output  WORD_WIDTH  instruction presented to the decoder instr_i.
REQ-013 pc_o  output  WORD_WIDTH  address of instr_o.
REQ-014 no_op_flag_o  output  1  drives decoder no_op_flag_i; 1 = no valid instruction.
REQ-015 stall_i  input  1  pipeline holds the current instruction.
REQ-016 branch_i  input  1  redirect fetch (jump/branch taken).
REQ-017 branch_target_i  input  WORD_WIDTH  redirect address.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID, DISCARD.
REQ-019 IDLE -> WAIT_GNT when count + outstanding < FIFO_DEPTH; instr_req_o=1 in WAIT_GNT only.
REQ-020 WAIT_GNT: instr_req_o and instr_addr_o SHALL hold until instr_gnt_i=1, then -> WAIT_RVALID and fetch address += 4.
REQ-021 WAIT_RVALID: on instr_rvalid_i=1, {instr_rdata_i, address} SHALL be pushed into the FIFO; the FSM SHALL then go to WAIT_GNT if space remains, else IDLE.
REQ-022 At most one request SHALL be outstanding.
REQ-023 instr_o/pc_o SHALL show the FIFO head; a pushed word SHALL appear one cycle after rvalid (no bypass).
REQ-024 When the FIFO is empty: no_op_flag_o=1, instr_o=32'h0000_0013 (NOP), pc_o holds its last value.
REQ-025 Pop SHALL occur on a rising edge with FIFO non-empty, stall_i=0, branch_i=0.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; the FIFO SHALL never overflow or underflow.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 branch_i=1 SHALL clear the FIFO and set the fetch address to {branch_target_i[31:2], 2'b00} at the next edge; it has priority over pop and push.
REQ-029 branch_i in WAIT_GNT SHALL switch instr_addr_o to the target in the following cycle, with req held high; on grant the FSM proceeds normally.
REQ-030 branch_i in WAIT_RVALID SHALL move the FSM to DISCARD; DISCARD SHALL drop the next rvalid word, then go to WAIT_GNT at the target.
REQ-031 branch_i coincident with instr_rvalid_i in WAIT_RVALID SHALL drop that word and go directly to WAIT_GNT at the target.
REQ-032 no_op_flag_o SHALL be 1 in the cycle branch_i is high.

Reset
REQ-033 During reset: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_o=32'h0000_0013, pc_o=BOOT_ADDR, no_op_flag_o=1, FIFO empty, FSM=IDLE.
REQ-034 Reset asserted mid-transaction SHALL abandon the outstanding request; first req after release SHALL target BOOT_ADDR.

Verification
REQ-035 Release reset, gnt same cycle, rvalid next cycle with 32'h0050_0093 -> instr_o=32'h0050_0093, pc_o=0, no_op_flag_o=0 one cycle later; next req addr=4.
REQ-036 stall_i=1 with memory always ready -> exactly 2 entries fetched (addr 0,4), instr_req_o=0 afterward, instr_o held at addr 0 word.
REQ-037 branch_i=1, target 32'h0000_0102 while in WAIT_RVALID -> returned word dropped, next req addr=32'h0000_0100, no_op_flag_o=1 until target word arrives.
REQ-038 gnt held low 5 cycles with branch to 32'h80 in cycle 2 -> req stays 1, addr=32'h80 from cycle 3, granted fetch returns pc_o=32'h80.
REQ-039 Push and pop same cycle with count=1 -> count stays 1, pc_o advances by 4, pointers wrap after 2 pops.
REQ-040 rst_n asserted in WAIT_RVALID -> outputs at reset values immediately; a late rvalid after release is ignored.
